// File: rtl/apb_pkg.sv
// Shared definitions for the APB master bridge: FSM state type and default sizing.
// Ports: none (package only).
// Imported by the bridge top, its wait timer and the bus interface.
package apb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } apb_state_e;

  localparam int DEF_ADDR_W  = 8;
  localparam int DEF_DATA_W  = 8;
  localparam int DEF_TIMEOUT = 16;
  // Address bit that steers a command to slave 2 (1) or slave 1 (0).
  localparam int SEL_BIT     = DEF_ADDR_W - 1;

endpackage

// File: rtl/apb_master_bridge_if.sv
// Bundles the request bus and the two-slave APB bus of the bridge.
// Ports: request side (transfer, read_write, addresses, data, done/err) and
// APB side (paddr, pwrite, pwdata, psel1/2, penable, prdata1/2, pready1/2).
interface apb_master_bridge_if
  import apb_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W
);
  logic              transfer;
  logic              read_write;
  logic [ADDR_W-1:0] apb_write_paddr;
  logic [DATA_W-1:0] apb_write_data;
  logic [ADDR_W-1:0] apb_read_paddr;
  logic [DATA_W-1:0] apb_read_data_out;
  logic              xfer_done;
  logic              xfer_err;
  logic [ADDR_W-1:0] paddr;
  logic              pwrite;
  logic [DATA_W-1:0] pwdata;
  logic              psel1;
  logic              psel2;
  logic              penable;
  logic [DATA_W-1:0] prdata1;
  logic [DATA_W-1:0] prdata2;
  logic              pready1;
  logic              pready2;

  // Bridge side.
  modport master (
    input  transfer, read_write, apb_write_paddr, apb_write_data, apb_read_paddr,
    input  prdata1, prdata2, pready1, pready2,
    output apb_read_data_out, xfer_done, xfer_err,
    output paddr, pwrite, pwdata, psel1, psel2, penable
  );

  // Requester plus slaves side.
  modport slave (
    output transfer, read_write, apb_write_paddr, apb_write_data, apb_read_paddr,
    output prdata1, prdata2, pready1, pready2,
    input  apb_read_data_out, xfer_done, xfer_err,
    input  paddr, pwrite, pwdata, psel1, psel2, penable
  );
endinterface

// File: rtl/apb_wait_timer.sv
// Counts ACCESS wait cycles; expired_o flags the last permitted wait cycle.
// Ports: clk, rst_n, clr_i (restart count), en_i (count one wait), expired_o.
// The count saturates at TIMEOUT-1 so it never wraps if left enabled.
module apb_wait_timer
  import apb_pkg::*;
#(
  parameter int TIMEOUT = DEF_TIMEOUT
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr_i,
  input  logic en_i,
  output logic expired_o
);
  localparam int CNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  assign expired_o = (cnt_q == LAST);

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i)                 cnt_d = '0;
    else if (en_i && !expired_o) cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end
endmodule

// File: rtl/apb_master_bridge.sv
// Runs one APB SETUP/ACCESS transfer per request, routed to slave 1 or 2 by address MSB.
// Ports: pclk, presetn, bus (request + APB signals, master modport).
// All outputs registered; a request arriving on completion chains straight into SETUP.
module apb_master_bridge
  import apb_pkg::*;
#(
  parameter int ADDR_W  = DEF_ADDR_W,
  parameter int DATA_W  = DEF_DATA_W,
  parameter int TIMEOUT = DEF_TIMEOUT
) (
  input  logic pclk,
  input  logic presetn,
  apb_master_bridge_if.master bus
);
  apb_state_e        state_q, state_d;
  logic [ADDR_W-1:0] paddr_q, paddr_d;
  logic [DATA_W-1:0] pwdata_q, pwdata_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              pwrite_q, pwrite_d;
  logic              psel1_q, psel1_d;
  logic              psel2_q, psel2_d;
  logic              penable_q, penable_d;
  logic              done_q, done_d;
  logic              err_q, err_d;

  logic              timer_clr, timer_en, timer_expired;
  logic              load_req;
  logic              sel_ready;
  logic [DATA_W-1:0] sel_rdata;
  logic [ADDR_W-1:0] req_addr;

  apb_wait_timer #(.TIMEOUT(TIMEOUT)) u_timer (
    .clk       (pclk),
    .rst_n     (presetn),
    .clr_i     (timer_clr),
    .en_i      (timer_en),
    .expired_o (timer_expired)
  );

  // Only the currently selected slave's handshake is looked at.
  assign sel_ready = psel2_q ? bus.pready2 : bus.pready1;
  assign sel_rdata = psel2_q ? bus.prdata2 : bus.prdata1;
  assign req_addr  = bus.read_write ? bus.apb_read_paddr : bus.apb_write_paddr;

  always_comb begin
    state_d   = state_q;
    paddr_d   = paddr_q;
    pwdata_d  = pwdata_q;
    rdata_d   = rdata_q;
    pwrite_d  = pwrite_q;
    psel1_d   = psel1_q;
    psel2_d   = psel2_q;
    penable_d = penable_q;
    done_d    = 1'b0;
    err_d     = 1'b0;
    timer_clr = 1'b0;
    timer_en  = 1'b0;
    load_req  = 1'b0;

    case (state_q)
      IDLE: begin
        psel1_d   = 1'b0;
        psel2_d   = 1'b0;
        penable_d = 1'b0;
        load_req  = bus.transfer;
      end
      SETUP: begin
        state_d   = ACCESS;
        penable_d = 1'b1;
      end
      ACCESS: begin
        if (sel_ready) begin
          done_d    = 1'b1;
          if (!pwrite_q) rdata_d = sel_rdata;
          state_d   = IDLE;
          psel1_d   = 1'b0;
          psel2_d   = 1'b0;
          penable_d = 1'b0;
          load_req  = bus.transfer;
        end else if (timer_expired) begin
          // Abort never chains a new request, even if one is pending.
          done_d    = 1'b1;
          err_d     = 1'b1;
          state_d   = IDLE;
          psel1_d   = 1'b0;
          psel2_d   = 1'b0;
          penable_d = 1'b0;
        end else begin
          timer_en  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    // Latching a request overrides the IDLE/completion defaults above.
    if (load_req) begin
      state_d   = SETUP;
      timer_clr = 1'b1;
      pwrite_d  = ~bus.read_write;
      paddr_d   = req_addr;
      if (!bus.read_write) pwdata_d = bus.apb_write_data;
      psel1_d   = ~req_addr[ADDR_W-1];
      psel2_d   = req_addr[ADDR_W-1];
      penable_d = 1'b0;
    end
  end

  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      state_q   <= IDLE;
      paddr_q   <= '0;
      pwdata_q  <= '0;
      rdata_q   <= '0;
      pwrite_q  <= 1'b0;
      psel1_q   <= 1'b0;
      psel2_q   <= 1'b0;
      penable_q <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      paddr_q   <= paddr_d;
      pwdata_q  <= pwdata_d;
      rdata_q   <= rdata_d;
      pwrite_q  <= pwrite_d;
      psel1_q   <= psel1_d;
      psel2_q   <= psel2_d;
      penable_q <= penable_d;
      done_q    <= done_d;
      err_q     <= err_d;
    end
  end

  assign bus.paddr             = paddr_q;
  assign bus.pwrite            = pwrite_q;
  assign bus.pwdata            = pwdata_q;
  assign bus.psel1             = psel1_q;
  assign bus.psel2             = psel2_q;
  assign bus.penable           = penable_q;
  assign bus.apb_read_data_out = rdata_q;
  assign bus.xfer_done         = done_q;
  assign bus.xfer_err          = err_q;
endmodule

// File: tb/tb_apb_master_bridge.sv
// Self-checking bench for apb_master_bridge: directed scenarios plus random traffic.
// Ports: none (top-level bench); drives the bus interface and clocks pclk.
// Inputs change at negedge (+#2 for reset); outputs are compared at negedge.
module tb_apb_master_bridge;
  localparam int TIMEOUT = 16;

  logic pclk = 1'b0;
  logic presetn = 1'b0;
  always #5 pclk = ~pclk;

  apb_master_bridge_if #(.ADDR_W(8), .DATA_W(8)) bus ();

  apb_master_bridge #(.ADDR_W(8), .DATA_W(8), .TIMEOUT(TIMEOUT)) dut (
    .pclk    (pclk),
    .presetn (presetn),
    .bus     (bus.master)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [29:0] dut_vec();
    return {bus.apb_read_data_out, bus.xfer_done, bus.xfer_err, bus.paddr, bus.pwrite,
            bus.pwdata, bus.psel1, bus.psel2, bus.penable};
  endfunction

  // Transaction-level reference: a transfer is "active" for cyc = 0 (setup)
  // then cyc = 1.. (access cycles); waits allowed = TIMEOUT-1.
  logic       m_act, m_write, m_done, m_err;
  int         m_cyc;
  logic [7:0] m_addr, m_wdata, m_rdata;

  task automatic m_start();
    m_act   = 1'b1;
    m_cyc   = 0;
    m_write = ~bus.read_write;
    m_addr  = bus.read_write ? bus.apb_read_paddr : bus.apb_write_paddr;
    if (!bus.read_write) m_wdata = bus.apb_write_data;
  endtask

  always @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      m_act = 0; m_cyc = 0; m_write = 0; m_done = 0; m_err = 0;
      m_addr = 0; m_wdata = 0; m_rdata = 0;
    end else begin
      m_done = 0;
      m_err  = 0;
      if (!m_act) begin
        if (bus.transfer) m_start();
      end else if (m_cyc == 0) begin
        m_cyc = 1;
      end else if (m_addr[7] ? bus.pready2 : bus.pready1) begin
        m_done = 1;
        if (!m_write) m_rdata = m_addr[7] ? bus.prdata2 : bus.prdata1;
        m_act = 0;
        if (bus.transfer) m_start();
      end else if (m_cyc == TIMEOUT) begin
        m_done = 1;
        m_err  = 1;
        m_act  = 0;
      end else begin
        m_cyc++;
      end
    end
  end

  function automatic logic [29:0] model_vec();
    return {m_rdata, m_done, m_err, m_addr, m_write, m_wdata,
            m_act && !m_addr[7], m_act && m_addr[7], m_act && (m_cyc >= 1)};
  endfunction

  always @(negedge pclk) chk("cycle_compare", 32'(dut_vec()), 32'(model_vec()));

  task automatic idle_inputs();
    bus.transfer = 0; bus.read_write = 0;
    bus.apb_write_paddr = 0; bus.apb_write_data = 0; bus.apb_read_paddr = 0;
    bus.prdata1 = 0; bus.prdata2 = 0; bus.pready1 = 0; bus.pready2 = 0;
  endtask

  int n_s1, n_s2, n_en, n_dn, n_er;
  logic p1 [8];
  logic p2 [8];
  logic en [8];
  logic dn [8];

  initial begin
    idle_inputs();
    repeat (3) @(negedge pclk);
    chk("reset_state", 32'(dut_vec()), 32'h0);
    #2 presetn = 1'b1;
    @(negedge pclk);
    chk("idle_after_reset", 32'(dut_vec()), 32'h0);

    // Single write, zero wait states, slave 1.
    bus.transfer = 1; bus.read_write = 0; bus.apb_write_paddr = 8'h05;
    bus.apb_write_data = 8'hA5; bus.pready1 = 1; bus.pready2 = 0;
    n_s1 = 0; n_en = 0; n_dn = 0; n_er = 0;
    for (int c = 0; c < 6; c++) begin
      @(negedge pclk);
      bus.transfer = 0;
      if (bus.psel1) begin
        n_s1++;
        chk("wr_paddr", 32'(bus.paddr), 32'h05);
        chk("wr_pwdata", 32'(bus.pwdata), 32'hA5);
        chk("wr_pwrite", 32'(bus.pwrite), 32'h1);
      end
      n_en += int'(bus.penable); n_dn += int'(bus.xfer_done); n_er += int'(bus.xfer_err);
    end
    chk("wr_psel1_cycles", n_s1, 2);
    chk("wr_penable_cycles", n_en, 1);
    chk("wr_done_count", n_dn, 1);
    chk("wr_err_count", n_er, 0);

    // Read from slave 2 with 3 wait states; slave 1 ready is a distractor.
    bus.transfer = 1; bus.read_write = 1; bus.apb_read_paddr = 8'h83;
    bus.pready2 = 0; bus.prdata2 = 8'h3C; bus.pready1 = 1; bus.prdata1 = 8'h77;
    n_s1 = 0; n_s2 = 0; n_en = 0; n_dn = 0;
    for (int c = 0; c < 12; c++) begin
      @(negedge pclk);
      bus.transfer = 0;
      n_s1 += int'(bus.psel1); n_s2 += int'(bus.psel2);
      n_en += int'(bus.penable); n_dn += int'(bus.xfer_done);
      if (n_en == 4) bus.pready2 = 1;
    end
    chk("rd2_psel1_cycles", n_s1, 0);
    chk("rd2_psel2_cycles", n_s2, 5);
    chk("rd2_penable_cycles", n_en, 4);
    chk("rd2_done_count", n_dn, 1);
    chk("rd2_rdata", 32'(bus.apb_read_data_out), 32'h3C);
    chk("model_rdata_pin", 32'(m_rdata), 32'h3C);

    // Back-to-back: write 0x10 (slave 1) then read 0x90 (slave 2), transfer held.
    bus.transfer = 1; bus.read_write = 0; bus.apb_write_paddr = 8'h10;
    bus.apb_write_data = 8'hC3; bus.pready1 = 1; bus.pready2 = 1; bus.prdata2 = 8'h5A;
    for (int c = 0; c < 8; c++) begin
      @(negedge pclk);
      p1[c] = bus.psel1; p2[c] = bus.psel2; en[c] = bus.penable; dn[c] = bus.xfer_done;
      if (c == 1) begin bus.read_write = 1; bus.apb_read_paddr = 8'h90; end
      if (c == 2) bus.transfer = 0;
    end
    chk("b2b_setup1", {p1[0], p2[0], en[0]}, 3'b100);
    chk("b2b_access1", {p1[1], p2[1], en[1]}, 3'b101);
    chk("b2b_setup2", {p1[2], p2[2], en[2], dn[2]}, 4'b0101);
    chk("b2b_access2", {p1[3], p2[3], en[3]}, 3'b011);
    chk("b2b_done2", {p1[4], p2[4], en[4], dn[4]}, 4'b0001);
    chk("b2b_rdata", 32'(bus.apb_read_data_out), 32'h5A);

    // Timeout on slave 1; slave 2 ready must be ignored.
    bus.transfer = 1; bus.read_write = 1; bus.apb_read_paddr = 8'h01;
    bus.pready1 = 0; bus.pready2 = 1; bus.prdata1 = 8'hFF; bus.prdata2 = 8'hEE;
    n_en = 0; n_dn = 0; n_er = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge pclk);
      bus.transfer = 0;
      n_en += int'(bus.penable);
      if (bus.xfer_done && bus.xfer_err) n_er++;
      n_dn += int'(bus.xfer_done);
    end
    chk("to_penable_cycles", n_en, 16);
    chk("to_done_count", n_dn, 1);
    chk("to_done_with_err", n_er, 1);
    chk("to_rdata_kept", 32'(bus.apb_read_data_out), 32'h5A);
    chk("to_idle", {bus.psel1, bus.psel2, bus.penable}, 3'b000);

    // Cross-slave isolation: slave 2 ready/data never taken for a slave-1 read.
    bus.transfer = 1; bus.read_write = 1; bus.apb_read_paddr = 8'h04;
    bus.pready1 = 0; bus.pready2 = 1; bus.prdata1 = 8'h11; bus.prdata2 = 8'hEE;
    n_en = 0; n_dn = 0;
    for (int c = 0; c < 10; c++) begin
      @(negedge pclk);
      bus.transfer = 0;
      n_en += int'(bus.penable); n_dn += int'(bus.xfer_done);
      if (n_en == 3) bus.pready1 = 1;
    end
    chk("iso_penable_cycles", n_en, 3);
    chk("iso_done_count", n_dn, 1);
    chk("iso_rdata", 32'(bus.apb_read_data_out), 32'h11);

    // Reset during a stalled read, then a normal write.
    bus.transfer = 1; bus.read_write = 1; bus.apb_read_paddr = 8'h02; bus.pready1 = 0;
    repeat (4) begin @(negedge pclk); bus.transfer = 0; end
    chk("rst_pre_access", 32'(bus.penable), 32'h1);
    #2 presetn = 1'b0;
    #1 chk("rst_async_zero", 32'(dut_vec()), 32'h0);
    n_dn = 0;
    repeat (3) begin @(negedge pclk); n_dn += int'(bus.xfer_done); end
    chk("rst_no_done", n_dn, 0);
    #2 presetn = 1'b1;
    @(negedge pclk);
    bus.transfer = 1; bus.read_write = 0; bus.apb_write_paddr = 8'h85;
    bus.apb_write_data = 8'h69; bus.pready2 = 1;
    n_s2 = 0; n_dn = 0;
    for (int c = 0; c < 6; c++) begin
      @(negedge pclk);
      bus.transfer = 0;
      n_s2 += int'(bus.psel2); n_dn += int'(bus.xfer_done);
    end
    chk("post_rst_psel2", n_s2, 2);
    chk("post_rst_done", n_dn, 1);
    chk("post_rst_pwdata", 32'(bus.pwdata), 32'h69);

    // Random traffic against the model, with occasional long stalls and resets.
    begin
      int stall_left = 0;
      for (int i = 0; i < 4000; i++) begin
        @(negedge pclk);
        bus.transfer        = ($urandom_range(0, 2) != 0);
        bus.read_write      = 1'($urandom_range(0, 1));
        bus.apb_write_paddr = 8'($urandom);
        bus.apb_read_paddr  = 8'($urandom);
        bus.apb_write_data  = 8'($urandom);
        bus.prdata1         = 8'($urandom);
        bus.prdata2         = 8'($urandom);
        if (stall_left > 0) begin
          stall_left--;
          bus.pready1 = 0; bus.pready2 = 0;
        end else begin
          bus.pready1 = ($urandom_range(0, 3) != 0);
          bus.pready2 = ($urandom_range(0, 3) != 0);
          if ($urandom_range(0, 99) == 0) stall_left = 20;
        end
        if ($urandom_range(0, 799) == 0) begin
          #2 presetn = 1'b0;
          @(negedge pclk);
          #2 presetn = 1'b1;
        end
      end
    end

    idle_inputs();
    repeat (3) @(negedge pclk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
